valu_ctrl_seq: RTL and testbench

- Control sequencer driving the ctrl modport of Valu_ctrl_if; the initiator end whose responder is the vector ALU datapath.
- Accepts decoded vector ops from the issue stage via valid/ready.
- Tracks each op through the multiplier and adder pipe slots and drives per-stage pipe enables and per-unit configuration.
- Interlocks accumulator read-after-write hazards; flags result-valid to writeback.

---
 rtl/valu_ctrl_seq_pkg.sv | 72 +++++++
 rtl/valu_ctrl_seq_if.sv | 44 ++++
 rtl/valu_ctrl_seq_acc_scoreboard.sv | 46 ++++
 rtl/valu_ctrl_seq.sv | 138 +++++++++++++
 tb/tb_valu_ctrl_seq.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/valu_ctrl_seq_pkg.sv
// Shared types for the vector ALU control sequencer.
//   Pu_inst  : issue-stage condition encoding (Fxv_cond).
//   Valu_pkg : datapath width/selector enums, the decoded Valu_op bundle,
//              the all-zero VALU_OP_NOP and the accumulator-read helper.
package Pu_inst;

  typedef enum logic [2:0] {
    COND_ALWAYS,
    COND_EQ,
    COND_NE,
    COND_LT,
    COND_GE,
    COND_NEVER
  } Fxv_cond;

endpackage

package Valu_pkg;

  import Pu_inst::*;

  typedef enum logic [1:0] {
    VT_BYTE,
    VT_HALF,
    VT_WORD,
    VT_DWORD
  } Valu_type;

  typedef enum logic [1:0] {
    ADD_IN_MULT,
    ADD_IN_ACCUM,
    ADD_IN_SRC,
    ADD_IN_ZERO
  } Valu_add_sel;

  typedef enum logic [1:0] {
    RES_ADDER,
    RES_MULT,
    RES_ACCUM,
    RES_SRC
  } Valu_res_sel;

  typedef struct packed {
    Valu_type    mult_conf;
    Valu_type    add_conf;
    Valu_type    round_conf;
    Valu_add_sel add_in_a_sel;
    Valu_add_sel add_in_b_sel;
    Valu_res_sel result_sel;
    logic        saturate;
    logic        mult_saturating;
    logic        shift_fractional;
    logic        mult_by_one;
    logic [4:0]  mult_shift;
    logic        add_to_zero;
    logic        negate_b;
    Fxv_cond     cond;
    logic        save_to_accum;
    logic        reads_accum;
  } Valu_op;

  localparam Valu_op VALU_OP_NOP = '0;

  // Conservative: either adder input selecting the accumulator, or the
  // decoder's explicit flag, counts as an accumulator read.
  function automatic logic op_reads_accum(input Valu_op op);
    return op.reads_accum ||
           (op.add_in_a_sel == ADD_IN_ACCUM) ||
           (op.add_in_b_sel == ADD_IN_ACCUM);
  endfunction

endpackage

// File: rtl/valu_ctrl_seq_if.sv
// Control bundle between the sequencer and the vector ALU datapath.
//   modport ctrl : sequencer side, drives everything.
//   modport dp   : datapath side, receives everything.
// MULT_STAGES / ADD_STAGES size the per-stage pipe enables.
interface Valu_ctrl_if #(
  parameter int unsigned MULT_STAGES = 1,
  parameter int unsigned ADD_STAGES  = 1
);
  import Valu_pkg::*;

  logic [MULT_STAGES-1:0] mult_pipe_enable;
  logic [ADD_STAGES-1:0]  add_pipe_enable;
  logic                   stall;
  Valu_type               mult_conf;
  logic                   mult_saturating;
  logic                   mult_by_one;
  logic [4:0]             mult_shift;
  logic                   shift_fractional;
  Valu_type               add_conf;
  Valu_add_sel            add_in_a_sel;
  Valu_add_sel            add_in_b_sel;
  logic                   add_to_zero;
  logic                   negate_b;
  Pu_inst::Fxv_cond       cond;
  Valu_res_sel            result_sel;
  Valu_type               round_conf;
  logic                   saturate;
  logic                   save_to_accum;

  modport ctrl (
    output mult_pipe_enable, add_pipe_enable, stall,
    output mult_conf, mult_saturating, mult_by_one, mult_shift, shift_fractional,
    output add_conf, add_in_a_sel, add_in_b_sel, add_to_zero, negate_b, cond,
    output result_sel, round_conf, saturate, save_to_accum
  );

  modport dp (
    input mult_pipe_enable, add_pipe_enable, stall,
    input mult_conf, mult_saturating, mult_by_one, mult_shift, shift_fractional,
    input add_conf, add_in_a_sel, add_in_b_sel, add_to_zero, negate_b, cond,
    input result_sel, round_conf, saturate, save_to_accum
  );

endinterface

// File: rtl/valu_ctrl_seq_acc_scoreboard.sv
// Pending-accumulator-write counter and read-after-write interlock.
//   clk, reset      : core clock, async active-low reset
//   i_inc           : an op that will write the accumulator was accepted
//   i_dec           : the accumulator is written this cycle
//   i_flush         : drop all pending writes at the next edge
//   i_reads_accum   : the op offered by issue reads the accumulator
//   o_hazard        : that op must wait
module valu_ctrl_acc_scoreboard #(
  parameter int unsigned ACC_CNT_W = 3,
  parameter int unsigned MAX_PEND  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_dec,
  input  logic i_flush,
  input  logic i_reads_accum,
  output logic o_hazard
);

  logic [ACC_CNT_W-1:0] r_pend_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_acc <= '0;
    end else if (i_flush) begin
      r_pend_acc <= '0;
    end else if (i_inc && !i_dec) begin
      r_pend_acc <= r_pend_acc + ACC_CNT_W'(1);
    end else if (i_dec && !i_inc) begin
      r_pend_acc <= r_pend_acc - ACC_CNT_W'(1);
    end
  end

  // A write retiring this very cycle no longer blocks a reader: the reader
  // reaches the adder inputs several cycles after the write lands.
  assign o_hazard = i_reads_accum && (r_pend_acc != '0) &&
                    !((r_pend_acc == ACC_CNT_W'(1)) && i_dec);

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
    (i_dec && !i_inc) |-> (r_pend_acc != '0));

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    (i_inc && !i_dec) |-> (32'(r_pend_acc) < MAX_PEND));

endmodule

// File: rtl/valu_ctrl_seq.sv
// Vector ALU control sequencer: takes decoded ops from issue and walks them
// through MULT_STAGES multiplier slots then ADD_STAGES adder slots, driving
// per-stage enables and per-unit configuration onto Valu_ctrl_if.ctrl.
//   clk, reset            : core clock, async active-low reset
//   in_valid/in_ready     : issue handshake, in_op is the decoded op
//   wb_stall              : writeback back-pressure, freezes all slots
//   flush                 : only with VALU_CTRL_SEQ_FLUSH_EN defined; drops
//                           every in-flight op and pending accumulator write
//   ctrl                  : control bundle to the datapath
//   res_valid             : a result leaves the last adder slot this cycle
//   busy                  : any slot occupied
module valu_ctrl_seq
  import Valu_pkg::*;
#(
  parameter int unsigned MULT_STAGES = 1,
  parameter int unsigned ADD_STAGES  = 1,
  parameter int unsigned ACC_CNT_W   = 3
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      in_valid,
  output logic      in_ready,
  input  Valu_op    in_op,
  input  logic      wb_stall,
`ifdef VALU_CTRL_SEQ_FLUSH_EN
  input  logic      flush,
`endif
  Valu_ctrl_if.ctrl ctrl,
  output logic      res_valid,
  output logic      busy
);

  localparam int unsigned N    = MULT_STAGES + ADD_STAGES;
  localparam int unsigned LAST = N - 1;

  logic [N-1:0] r_valid;
  Valu_op       r_op [N];

  logic   w_flush;
  logic   w_advance;
  logic   w_hazard;
  logic   w_accept;
  logic   w_save;
  Valu_op w_s_mult;
  Valu_op w_s_add;
  Valu_op w_s_last;
  logic [MULT_STAGES-1:0] w_mult_en;
  logic [ADD_STAGES-1:0]  w_add_en;
  logic   w_unused_fields;

`ifdef VALU_CTRL_SEQ_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_advance = !wb_stall;
  assign in_ready  = !wb_stall && !w_hazard && !w_flush;
  assign w_accept  = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        r_op[i] <= VALU_OP_NOP;
      end
    end else if (w_flush) begin
      r_valid <= '0;
    end else if (w_advance) begin
      r_valid[0] <= w_accept;
      r_op[0]    <= w_accept ? in_op : VALU_OP_NOP;
      for (int unsigned i = 1; i < N; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_op[i]    <= r_op[i-1];
      end
    end
  end

  // Empty slots present the all-zero op so no field is left floating.
  assign w_s_mult = r_valid[0]           ? r_op[0]           : VALU_OP_NOP;
  assign w_s_add  = r_valid[MULT_STAGES] ? r_op[MULT_STAGES] : VALU_OP_NOP;
  assign w_s_last = r_valid[LAST]        ? r_op[LAST]        : VALU_OP_NOP;

  always_comb begin
    w_mult_en = '0;
    w_add_en  = '0;
    for (int unsigned i = 0; i < MULT_STAGES; i++) begin
      w_mult_en[i] = r_valid[i] && w_advance && !w_flush;
    end
    for (int unsigned j = 0; j < ADD_STAGES; j++) begin
      w_add_en[j] = r_valid[MULT_STAGES+j] && w_advance && !w_flush;
    end
  end

  assign w_save    = r_valid[LAST] && w_s_last.save_to_accum && w_advance && !w_flush;
  assign res_valid = r_valid[LAST] && w_advance && !w_flush;
  assign busy      = |r_valid;

  assign ctrl.mult_pipe_enable = w_mult_en;
  assign ctrl.add_pipe_enable  = w_add_en;
  // Gated by reset so the whole bundle reads zero while reset is held.
  assign ctrl.stall            = wb_stall && reset;

  assign ctrl.mult_conf        = w_s_mult.mult_conf;
  assign ctrl.mult_saturating  = w_s_mult.mult_saturating;
  assign ctrl.mult_by_one      = w_s_mult.mult_by_one;
  assign ctrl.mult_shift       = w_s_mult.mult_shift;
  assign ctrl.shift_fractional = w_s_mult.shift_fractional;

  assign ctrl.add_conf         = w_s_add.add_conf;
  assign ctrl.add_in_a_sel     = w_s_add.add_in_a_sel;
  assign ctrl.add_in_b_sel     = w_s_add.add_in_b_sel;
  assign ctrl.add_to_zero      = w_s_add.add_to_zero;
  assign ctrl.negate_b         = w_s_add.negate_b;
  assign ctrl.cond             = w_s_add.cond;

  assign ctrl.result_sel       = w_s_last.result_sel;
  assign ctrl.round_conf       = w_s_last.round_conf;
  assign ctrl.saturate         = w_s_last.saturate;
  assign ctrl.save_to_accum    = w_save;

  // Each slot view only feeds its own unit's fields.
  assign w_unused_fields = ^{w_s_mult, w_s_add, w_s_last};

  valu_ctrl_acc_scoreboard #(
    .ACC_CNT_W (ACC_CNT_W),
    .MAX_PEND  (N)
  ) u_acc_sb (
    .clk           (clk),
    .reset         (reset),
    .i_inc         (w_accept && in_op.save_to_accum),
    .i_dec         (w_save),
    .i_flush       (w_flush),
    .i_reads_accum (op_reads_accum(in_op)),
    .o_hazard      (w_hazard)
  );

endmodule

// File: tb/tb_valu_ctrl_seq.sv
// Self-checking bench for valu_ctrl_seq with two multiplier and two adder
// slots. Accepted ops are queued with their due cycle; the negedge monitor
// pops them when a result is expected and compares the writeback fields.
// Directed sections cover latency, throughput, the accumulator interlock,
// stalls, mid-flight reset and (with VALU_CTRL_SEQ_FLUSH_EN) flush.
module tb_valu_ctrl_seq;
  import Pu_inst::*;
  import Valu_pkg::*;

  localparam int unsigned M   = 2;
  localparam int unsigned A   = 2;
  localparam int          LAT = M + A;

  logic   clk      = 1'b0;
  logic   reset    = 1'b0;
  logic   in_valid = 1'b0;
  logic   wb_stall = 1'b0;
  Valu_op in_op    = VALU_OP_NOP;
  logic   in_ready;
  logic   res_valid;
  logic   busy;
`ifdef VALU_CTRL_SEQ_FLUSH_EN
  logic   flush    = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    Valu_res_sel rs;
    Valu_type    rc;
    logic        sat;
    logic        save;
    int          due;
  } exp_t;

  exp_t q[$];

  Valu_ctrl_if #(.MULT_STAGES(M), .ADD_STAGES(A)) vif ();

  valu_ctrl_seq #(
    .MULT_STAGES (M),
    .ADD_STAGES  (A),
    .ACC_CNT_W   (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .wb_stall  (wb_stall),
`ifdef VALU_CTRL_SEQ_FLUSH_EN
    .flush     (flush),
`endif
    .ctrl      (vif),
    .res_valid (res_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic Valu_op mk(input Valu_type mc, input Valu_res_sel rs,
                                input logic save, input logic racc);
    Valu_op o;
    o = VALU_OP_NOP;
    o.mult_conf     = mc;
    o.add_conf      = mc;
    o.round_conf    = mc;
    o.result_sel    = rs;
    o.saturate      = (rs == RES_MULT);
    o.mult_shift    = 5'd3;
    o.cond          = COND_EQ;
    o.save_to_accum = save;
    if (racc) begin
      o.add_in_b_sel = ADD_IN_ACCUM;
      o.reads_accum  = 1'b1;
    end
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_op    = VALU_OP_NOP;
    repeat (n) tick();
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic dropping;
    logic exp_rv;
    exp_t e;
    dropping = !reset;
`ifdef VALU_CTRL_SEQ_FLUSH_EN
    dropping = dropping || flush;
`endif
    if (dropping) begin
      check("rv_dropped", res_valid, 0);
      q.delete();
    end else begin
      if (wb_stall) begin
        foreach (q[i]) q[i].due++;
      end
      exp_rv = (q.size() > 0) && (q[0].due == cyc);
      check("res_valid", res_valid, exp_rv);
      if (exp_rv) begin
        e = q.pop_front();
        if (res_valid) begin
          check("result_sel", vif.result_sel, e.rs);
          check("round_conf", vif.round_conf, e.rc);
          check("saturate", vif.saturate, e.sat);
          check("save_to_accum", vif.save_to_accum, e.save);
        end
      end
      if (in_valid && in_ready) begin
        e.rs   = in_op.result_sel;
        e.rc   = in_op.round_conf;
        e.sat  = in_op.saturate;
        e.save = in_op.save_to_accum;
        e.due  = cyc + LAT;
        q.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc_cyc;

    // Reset state
    #12;
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_mult_en", vif.mult_pipe_enable, 0);
    check("rst_add_en", vif.add_pipe_enable, 0);
    check("rst_stall", vif.stall, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    tick();
    check("rel_in_ready", in_ready, 1);

    // 1: single op latency and per-stage enables
    for (int k = 0; k < 6; k++) begin
      in_valid = (k == 0);
      in_op    = (k == 0) ? mk(VT_HALF, RES_MULT, 1'b0, 1'b0) : VALU_OP_NOP;
      @(negedge clk);
      check("t1_mult_en", vif.mult_pipe_enable, (k == 1) ? 1 : (k == 2) ? 2 : 0);
      check("t1_add_en", vif.add_pipe_enable, (k == 3) ? 1 : (k == 4) ? 2 : 0);
      check("t1_mult_conf", vif.mult_conf, (k == 1) ? VT_HALF : VT_BYTE);
      check("t1_res_valid", res_valid, k == 4);
      tick();
    end

    // 2: four independent ops back to back
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_op    = mk(Valu_type'(k), Valu_res_sel'(k), 1'b0, 1'b0);
      @(negedge clk);
      check("t2_in_ready", in_ready, 1);
      tick();
    end
    idle(LAT + 2);

    // 3: accumulator read-after-write interlock
    in_valid = 1'b1;
    in_op    = mk(VT_WORD, RES_ACCUM, 1'b1, 1'b0);
    @(negedge clk);
    check("t3_a_ready", in_ready, 1);
    tick();
    in_op   = mk(VT_WORD, RES_ADDER, 1'b0, 1'b1);
    acc_cyc = -1;
    for (int k = 1; k < 12 && acc_cyc < 0; k++) begin
      @(negedge clk);
      check("t3_b_ready", in_ready, k >= 4);
      if (in_ready) acc_cyc = k;
      tick();
    end
    check("t3_b_accept_cycle", acc_cyc, 4);
    idle(LAT + 2);

    // 4: writeback stall for three cycles
    for (int k = 0; k < 11; k++) begin
      in_valid = (k < 2);
      in_op    = (k < 2) ? mk((k == 0) ? VT_HALF : VT_WORD, RES_SRC, 1'b0, 1'b0)
                         : VALU_OP_NOP;
      wb_stall = (k >= 2 && k <= 4);
      @(negedge clk);
      check("t4_ctrl_stall", vif.stall, wb_stall);
      if (wb_stall) begin
        check("t4_mult_en", vif.mult_pipe_enable, 0);
        check("t4_add_en", vif.add_pipe_enable, 0);
        check("t4_in_ready", in_ready, 0);
        check("t4_hold_conf", vif.mult_conf, VT_WORD);
      end
      if (k >= 2) check("t4_res_valid", res_valid, k == 7 || k == 8);
      tick();
    end
    wb_stall = 1'b0;
    idle(2);

    // 5: reset with three ops in flight and two accumulator writes pending
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_op    = mk(VT_DWORD, RES_ACCUM, k < 2, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    in_op    = VALU_OP_NOP;
    check("t5_busy_before", busy, 1);
    reset = 1'b0;
    #1;
    check("t5_res_valid", res_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_mult_en", vif.mult_pipe_enable, 0);
    check("t5_add_en", vif.add_pipe_enable, 0);
    check("t5_result_sel", vif.result_sel, RES_ADDER);
    check("t5_save", vif.save_to_accum, 0);
    @(posedge clk);
    #3 reset = 1'b1;
    tick();
    in_valid = 1'b1;
    in_op    = mk(VT_BYTE, RES_ADDER, 1'b0, 1'b1);
    @(negedge clk);
    check("t5_busy_after", busy, 0);
    check("t5_in_ready_after", in_ready, 1);
    tick();
    idle(LAT + 2);

`ifdef VALU_CTRL_SEQ_FLUSH_EN
    // 6: flush drops in-flight ops and pending accumulator writes
    for (int k = 0; k < 4; k++) begin
      in_valid = (k != 2);
      in_op    = (k == 0) ? mk(VT_WORD, RES_ACCUM, 1'b1, 1'b0)
               : (k == 1) ? mk(VT_HALF, RES_MULT, 1'b0, 1'b0)
               :            mk(VT_BYTE, RES_ADDER, 1'b0, 1'b1);
      flush    = (k == 2);
      @(negedge clk);
      if (k == 2) begin
        check("t6_ready_flush", in_ready, 0);
        check("t6_rv_flush", res_valid, 0);
        check("t6_mult_en_flush", vif.mult_pipe_enable, 0);
        check("t6_add_en_flush", vif.add_pipe_enable, 0);
      end
      if (k == 3) check("t6_ready_after", in_ready, 1);
      tick();
    end
    flush = 1'b0;
    idle(LAT + 2);
`endif

    // Mixed random traffic with random stalls
    for (int k = 0; k < 60; k++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_op    = mk(Valu_type'($urandom_range(0, 3)), Valu_res_sel'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      wb_stall = ($urandom_range(0, 4) == 0);
      tick();
    end
    wb_stall = 1'b0;
    idle(LAT + 4);
    check("drain_queue_empty", q.size(), 0);
    check("drain_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
